uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Transmit-side byte buffer placed directly upstream of the UART transmitter. It accepts bytes from the system side with a single-cycle push strobe and stores them in a synchronous FIFO. It feeds the transmitter's `data_i`/`send`/`ready_tx` handshake one byte at a time. It holds each byte stable in an output register for the whole frame, so system logic never has to track frame timing.

## Interface
- `DEPTH_LOG2`, default 4: FIFO holds 2^DEPTH_LOG2 bytes (16).
- `GUARD_CYCLES`, default 2: idle `clk` cycles inserted after `ready_tx` returns high before the next launch. Must be ≥1 (≥2 required when the transmitter enable clears one edge after ready).
- `clk` input 1: system clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `data_i` input 8: byte to enqueue.
- `push` input 1: enqueue `data_i` this cycle.
- `full` output 1: FIFO memory holds 2^DEPTH_LOG2 bytes.
- `empty` output 1: FIFO memory holds 0 bytes.
- `count` output DEPTH_LOG2+1: bytes in FIFO memory; excludes the byte in flight.
- `overflow` output 1: sticky; a push was dropped.
- `busy` output 1: a byte is in flight (state ≠ IDLE).
- `data_o` output 8: byte presented to transmitter `data_i`.
- `send` output 1: launch request to transmitter `send`.
- `ready_tx` input 1: transmitter ready (idle) flag.

## Operation
- Storage: 2^DEPTH_LOG2 × 8 memory, write/read pointers of DEPTH_LOG2 bits wrapping modulo depth, occupancy counter of DEPTH_LOG2+1 bits. `full`/`empty` are decoded from the counter.
- Push: on `push` with not full, write at wptr and increment wptr and count.
- Push when full:
  - If a pop occurs the same cycle, the push is accepted and count stays at max.
  - Otherwise the byte is dropped, `overflow` is set, and stays set until `rst`.
- Launch FSM, states IDLE, LAUNCH, SENDING, GUARD:
  - IDLE: if `!empty & ready_tx`, pop: `data_o <= mem[rptr]`, increment rptr, decrement count (net 0 with a simultaneous push), `send <= 1`, go to LAUNCH. Otherwise stay.
  - LAUNCH: hold `send=1` until `ready_tx` is sampled 0. Then `send <= 0` and go to SENDING. `send` is a level held until acknowledged, so a transmitter whose internal enable is still clearing cannot miss it.
  - SENDING: wait for `ready_tx` sampled 1. Then load the guard counter with GUARD_CYCLES-1 and go to GUARD.
  - GUARD: decrement the counter. At 0, go to IDLE.
  - Undefined encodings go to IDLE.
- `data_o` changes only on the IDLE→LAUNCH edge. It is constant through LAUNCH, SENDING and GUARD.
- `busy` = state ≠ IDLE.
- Reset values: state IDLE, `send` 0, `data_o` 0x00, `count` 0, `empty` 1, `full` 0, `overflow` 0, `busy` 0, pointers 0, guard counter 0. Memory contents are not reset.
- Reset mid-operation (any state) discards the in-flight byte and all queued bytes. The transmitter is reset by the same `rst`, so no frame resumes.

## Timing
- Push sampled at edge N with the FSM idle and `ready_tx=1` → `empty` low after N. Pop decision at N+1 → `send` and new `data_o` valid after N+1. Push-to-send latency is 2 edges.
- `send` high for at least 1 cycle. It drops the cycle after `ready_tx=0` is first sampled.
- Back-to-back bytes: the next `send` rises no earlier than GUARD_CYCLES+1 edges after the edge at which `ready_tx` is sampled high.
- `count`, `full`, `empty` and `overflow` are registered and update on the edge of the push/pop.
- The push path is independent of FSM state. Pushes are accepted in every state.

## Test plan
- Reset: hold `rst` 3 cycles during a push burst → all outputs at reset values, `count=0`. First push after release is accepted.
- Single byte: push 0xA5 into idle block with a transmitter model (8N1) → `send` high 2 edges after push, `data_o=0xA5` stable until GUARD ends, line shows 0xA5, `count` back to 0.
- Burst/ordering: push 0x00, 0xFF, 0x55 on consecutive cycles → frames emitted in that order. Between frames, `send` rises ≥GUARD_CYCLES+1 edges after `ready_tx` rises. No `send` is lost.
- Full/overflow: stall `ready_tx=0`, push 0x01..0x11 (17 bytes) → `full` after 16th push, 17th dropped, `overflow=1`, `count=16`. Release `ready_tx` → 0x01..0x10 transmitted, pointers wrap correctly.
- Simultaneous push/pop at full: 16 queued, push 0x77 on the IDLE pop cycle → `count` stays 16, `overflow` stays 0, 0x77 transmitted last.
- Reset mid-frame: assert `rst` while in SENDING with 5 bytes queued → `send=0`, `busy=0`, `count=0` next cycle, no further frames.

Source files
------------

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_fifo                                                 |
// | Description : Transmit byte FIFO with launch FSM feeding a UART TX. Holds  |
// |               each byte stable on data_o for the whole frame and inserts   |
// |               GUARD_CYCLES idle cycles between frames.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_tx_fifo #(
  parameter int DEPTH_LOG2   = 4,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            data_i,
  input  logic                  push,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  busy,
  output logic [7:0]            data_o,
  output logic                  send,
  input  logic                  ready_tx
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  // Guard counter only needs to hold GUARD_CYCLES-1.
  localparam int GW    = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  localparam logic [GW-1:0]         GUARD_LOAD = GW'(GUARD_CYCLES - 1);
  localparam logic [GW-1:0]         GUARD_ONE  = GW'(1);
  localparam logic [DEPTH_LOG2:0]   COUNT_MAX  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LAUNCH  = 2'd1,
    S_SENDING = 2'd2,
    S_GUARD   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [7:0]              data_q, data_d;
  logic                    send_q, send_d;
  logic [GW-1:0]           guard_q, guard_d;
  logic [DEPTH_LOG2-1:0]   wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0]   rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]     count_q, count_d;
  logic                    overflow_q, overflow_d;
  logic [7:0]              mem [DEPTH];

  logic                    pop;
  logic                    push_ok;
  logic                    full_w;
  logic                    empty_w;

  assign full_w  = (count_q == COUNT_MAX);
  assign empty_w = (count_q == '0);

  // Launch FSM: pop one byte when idle, hold send until acknowledged, then guard.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    send_d  = send_q;
    guard_d = guard_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty_w && ready_tx) begin
          pop     = 1'b1;
          data_d  = mem[rptr_q];
          send_d  = 1'b1;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (!ready_tx) begin
          send_d  = 1'b0;
          state_d = S_SENDING;
        end
      end
      S_SENDING: begin
        if (ready_tx) begin
          guard_d = GUARD_LOAD;
          state_d = S_GUARD;
        end
      end
      S_GUARD: begin
        if (guard_q == '0) begin
          state_d = S_IDLE;
        end else begin
          guard_d = guard_q - GUARD_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        send_d  = 1'b0;
      end
    endcase
  end

  // FIFO bookkeeping: a push at full is still taken when the same cycle pops.
  always_comb begin
    push_ok    = push && (!full_w || pop);
    overflow_d = overflow_q || (push && full_w && !pop);
    wptr_d     = push_ok ? (wptr_q + PTR_ONE) : wptr_q;
    rptr_d     = pop ? (rptr_q + PTR_ONE) : rptr_q;
    count_d    = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + COUNT_ONE;
    end else if (!push_ok && pop) begin
      count_d = count_q - COUNT_ONE;
    end
  end

  // Storage array: write-only port here, contents survive reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr_q] <= data_i;
    end
  end

  // State and control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      data_q     <= 8'h00;
      send_q     <= 1'b0;
      guard_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      send_q     <= send_d;
      guard_q    <= guard_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign full     = full_w;
  assign empty    = empty_w;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != S_IDLE);
  assign data_o   = data_q;
  assign send     = send_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_tx_fifo                                              |
// | Description : Self-checking bench for uart_tx_fifo with an 8N1 transmitter |
// |               and line receiver, plus a queue-based reference model.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_uart_tx_fifo;

  localparam int DL2     = 4;
  localparam int DEPTH   = 16;
  localparam int GUARD   = 2;
  localparam int BIT_CYC = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   data_i;
  logic         push;
  logic         full, empty, overflow, busy, send;
  logic [DL2:0] count;
  logic [7:0]   data_o;
  logic         ready_tx;

  uart_tx_fifo #(.DEPTH_LOG2(DL2), .GUARD_CYCLES(GUARD)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .push(push),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .busy(busy), .data_o(data_o), .send(send), .ready_tx(ready_tx)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- 8N1 transmitter model ----------------
  logic       stall;
  logic       tx_busy;
  logic [9:0] tx_sh;
  int         tx_bits, tx_div;
  logic       line;

  assign ready_tx = !tx_busy && !stall;
  assign line     = tx_busy ? tx_sh[0] : 1'b1;

  always @(posedge clk) begin
    if (rst) begin
      tx_busy <= 1'b0;
      tx_sh   <= '1;
      tx_bits <= 0;
      tx_div  <= 0;
    end else if (!tx_busy) begin
      if (send && !stall) begin
        tx_busy <= 1'b1;
        tx_sh   <= {1'b1, data_o, 1'b0};
        tx_bits <= 10;
        tx_div  <= BIT_CYC - 1;
      end
    end else if (tx_div == 0) begin
      tx_sh   <= {1'b1, tx_sh[9:1]};
      tx_div  <= BIT_CYC - 1;
      tx_bits <= tx_bits - 1;
      if (tx_bits == 1) tx_busy <= 1'b0;
    end else begin
      tx_div <= tx_div - 1;
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [7:0] exp_q[$];   // accepted, not yet launched
  logic [7:0] gold_q[$];  // every accepted byte, in order
  logic [7:0] rx_q[$];    // bytes decoded from the line
  logic       exp_ovf = 1'b0;
  logic [7:0] inflight = 8'h00;
  int         edge_n = 0;
  int         rdy_rise_edge = -1000;
  int         last_launch_edge = -1000;
  int         n_launch = 0;
  int         rst_gen = 0;
  bit         in_frame = 0;
  bit         low_seen = 0;

  always @(posedge clk) begin : mon
    logic r, s_prev, p, rs, busy_prev, rose;
    logic [7:0] d, e;
    int pre_size;
    r = ready_tx; s_prev = send; p = push; d = data_i; rs = rst; busy_prev = busy;
    edge_n++;
    pre_size = exp_q.size();
    #1;
    if (rs) begin
      exp_q.delete(); gold_q.delete(); rx_q.delete();
      exp_ovf = 1'b0; inflight = 8'h00; in_frame = 0; low_seen = 0;
      rdy_rise_edge = -1000; last_launch_edge = -1000; rst_gen++;
    end else begin
      rose = send && !s_prev;
      if (edge_n == rdy_rise_edge + GUARD + 1 && last_launch_edge < rdy_rise_edge && pre_size > 0 && r)
        check_eq("relaunch_on_time", rose, 1);
      if (rose) begin
        n_launch++;
        check_eq("launch_ready", r, 1);
        check_eq("launch_from_idle", busy_prev, 0);
        if (last_launch_edge >= 0 && rdy_rise_edge > last_launch_edge)
          check_eq("launch_gap", (edge_n - rdy_rise_edge) >= GUARD + 1, 1);
        check_eq("launch_with_data", pre_size > 0, 1);
        if (pre_size > 0) begin
          e = exp_q.pop_front();
          check_eq("launch_data", data_o, e);
          inflight = e;
        end
        last_launch_edge = edge_n;
        in_frame = 1;
        low_seen = 0;
      end else if (busy) begin
        check_eq("data_hold", data_o, inflight);
      end
      if (p) begin
        if (pre_size < DEPTH || rose) begin
          exp_q.push_back(d);
          gold_q.push_back(d);
        end else begin
          exp_ovf = 1'b1;
        end
      end
      if (s_prev) begin
        if (r) check_eq("send_hold", send, 1);
        else   check_eq("send_drop", send, 0);
      end
      if (in_frame && !rose) begin
        if (!r) low_seen = 1;
        else if (low_seen) begin
          rdy_rise_edge = edge_n;
          in_frame = 0;
        end
      end
      check_eq("count", count, exp_q.size());
      check_eq("full", full, exp_q.size() == DEPTH);
      check_eq("empty", empty, exp_q.size() == 0);
      check_eq("overflow", overflow, exp_ovf);
    end
  end

  // ---------------- line receiver ----------------
  initial begin : rx
    int g;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (!rst && line == 1'b0) begin
        g = rst_gen;
        repeat (BIT_CYC / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT_CYC) @(negedge clk);
          b[i] = line;
        end
        repeat (BIT_CYC) @(negedge clk);
        if (g == rst_gen) begin
          check_eq("rx_stop_bit", line, 1);
          rx_q.push_back(b);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_byte(input logic [7:0] b);
    data_i = b;
    push   = 1'b1;
    @(negedge clk);
    push   = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (k < 3000 && (exp_q.size() != 0 || busy || tx_busy)) begin
      @(negedge clk);
      k++;
    end
    check_eq("drain_done", k < 3000, 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic compare_rx(input string tag);
    check_eq({tag, "_frames"}, rx_q.size(), gold_q.size());
    for (int i = 0; i < rx_q.size() && i < gold_q.size(); i++)
      check_eq({tag, "_byte"}, rx_q[i], gold_q[i]);
    rx_q.delete();
    gold_q.delete();
  endtask

  initial begin : watchdog
    #600000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin : stim
    int snap, nb;
    bit reached;
    rst = 1'b1; push = 1'b0; data_i = 8'h00; stall = 1'b0;
    @(negedge clk);
    // Push burst while reset is held for three cycles.
    for (int i = 0; i < 3; i++) push_byte(8'hE0 + 8'(i));
    check_eq("rst_count", count, 0);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_full", full, 0);
    check_eq("rst_overflow", overflow, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_send", send, 0);
    check_eq("rst_data_o", data_o, 0);
    rst = 1'b0;
    push_byte(8'h3C);
    check_eq("first_push_count", count, 1);
    drain();
    compare_rx("first");

    // Single byte: send 2 edges after the push edge.
    push_byte(8'hA5);
    check_eq("single_send_early", send, 0);
    check_eq("single_not_empty", empty, 0);
    @(negedge clk);
    check_eq("single_send", send, 1);
    check_eq("single_data_o", data_o, 8'hA5);
    drain();
    check_eq("single_count_end", count, 0);
    compare_rx("single");

    // Burst ordering.
    data_i = 8'h00; push = 1'b1; @(negedge clk);
    data_i = 8'hFF; @(negedge clk);
    data_i = 8'h55; @(negedge clk);
    push = 1'b0;
    drain();
    compare_rx("burst");

    // Full / overflow with transmitter stalled.
    stall = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      push_byte(8'(i));
      if (i == 16) check_eq("full_at_16", full, 1);
    end
    check_eq("ovf_count", count, 16);
    check_eq("ovf_flag", overflow, 1);
    stall = 1'b0;
    drain();
    compare_rx("ovf");

    // Simultaneous push and pop at full.
    do_reset(2);
    stall = 1'b1;
    for (int i = 0; i < 16; i++) push_byte(8'h80 + 8'(i));
    check_eq("simul_full_count", count, 16);
    data_i = 8'h77; push = 1'b1; stall = 1'b0;
    @(negedge clk);
    push = 1'b0;
    check_eq("simul_count", count, 16);
    check_eq("simul_ovf", overflow, 0);
    drain();
    compare_rx("simul");

    // Randomized bursts, overflow allowed.
    for (int r = 0; r < 6; r++) begin
      nb = $urandom_range(4, 20);
      for (int j = 0; j < nb; j++) begin
        push_byte(8'($urandom));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      drain();
      compare_rx("rand");
    end

    // Reset while a frame is in flight with 5 bytes queued.
    do_reset(2);
    for (int i = 0; i < 6; i++) push_byte(8'hC0 + 8'(i));
    reached = 0;
    for (int k = 0; k < 200 && !reached; k++) begin
      if (busy && !send && !ready_tx && count == 5) reached = 1;
      else @(negedge clk);
    end
    check_eq("reach_sending", reached, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_send", send, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_count", count, 0);
    snap = n_launch;
    repeat (150) @(negedge clk);
    check_eq("midrst_no_launch", n_launch, snap);
    check_eq("midrst_no_frames", rx_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
